// File: rtl/fifo_pkg.sv
// Shared types and sizing for the FIFO burst reader slice.
package fifo_pkg;

  localparam int ADDRESSWIDTH = 5;
  localparam int DATAWIDTH    = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } rdr_state_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order valid/ready buffer that absorbs read data while the consumer stalls.
module fifo_skid_buf #(
  parameter int DW = fifo_pkg::DATAWIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy
);
  import fifo_pkg::*;

  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          head_q, head_d;
  logic [1:0]    count_q, count_d;
  logic          accept;
  logic          pop;

  // A push arriving while both slots are full is dropped.
  assign accept = push && (count_q != 2'd2);
  assign pop    = (count_q != 2'd0) && out_ready;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    count_d = count_q + {1'b0, accept} - {1'b0, pop};
    if (accept) begin
      mem_d[head_q ^ count_q[0]] = push_data;
    end
    if (pop) begin
      head_d = ~head_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = out_valid ? mem_q[head_q] : '0;
  assign occupancy = count_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a programmed number of FIFO entries and forwards them over valid/ready,
// issuing a read only when a buffer slot is already reserved for its data.
module fifo_burst_reader #(
  parameter int ADDRESSWIDTH = fifo_pkg::ADDRESSWIDTH,
  parameter int DATAWIDTH    = fifo_pkg::DATAWIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDRESSWIDTH:0] burst_len,
  input  logic                  emp,
  input  logic                  rd_en,
  input  logic [DATAWIDTH-1:0]  rd_data,
  output logic                  rd,
  output logic                  out_valid,
  output logic [DATAWIDTH-1:0]  out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  import fifo_pkg::*;

  localparam int LW = ADDRESSWIDTH + 1;

  rdr_state_t    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] issued_q, issued_d;
  logic          inflight_q, inflight_d;
  logic          err_q, err_d;
  logic [1:0]    occupancy;

  fifo_skid_buf #(
    .DW(DATAWIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_en),
    .push_data (rd_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // Buffered words plus the outstanding read must fit in the two skid slots.
  assign rd = (state_q == RUN) && !emp && (issued_q < len_q) &&
              (({1'b0, occupancy} + {2'b00, inflight_q}) < 3'd2);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = rd ? issued_q + LW'(1) : issued_q;
    inflight_d = rd ? 1'b1 : (rd_en ? 1'b0 : inflight_q);
    err_d      = err_q | (rd_en & ~inflight_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = burst_len;
          issued_d = '0;
          state_d  = (burst_len == '0) ? DONE : RUN;
        end
      end
      RUN:     if (issued_q == len_q) state_d = DRAIN;
      DRAIN:   if (!inflight_q && (occupancy == 2'd0)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign err  = err_q;

`ifndef SYNTHESIS
  a_no_rd_when_empty: assert property (@(posedge clk) disable iff (rst) !(rd && emp));
  a_slots_bounded: assert property (@(posedge clk) disable iff (rst)
    (({1'b0, occupancy} + {2'b00, inflight_q}) <= 3'd2));
  a_done_pulse: assert property (@(posedge clk) disable iff (rst) done |=> !done);
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench: models the FIFO controller and consumer, scoreboards delivered words.
module tb_fifo_burst_reader;

  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   burst_len;
  logic          emp;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .ADDRESSWIDTH(AW),
    .DATAWIDTH   (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .burst_len (burst_len),
    .emp       (emp),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd        (rd),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q  [$];
  logic [DW-1:0] got_q  [$];

  bit            pend_valid = 1'b0;
  logic [DW-1:0] pend_data  = '0;
  bit            start_req  = 1'b0;
  bit            spur_req   = 1'b0;
  bit            rst_req    = 1'b0;
  logic [AW:0]   len_req    = '0;
  int            ready_mode = 0;
  int            feed_left  = 0;
  int            cyc, rd_cnt, out_cnt, done_cnt, first_rd, first_ov;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    else passes++;
  endtask

  // One clock cycle: drive controller/consumer inputs at negedge, then sample and score.
  task automatic applyStimulus();
    logic [DW-1:0] w;
    @(negedge clk);
    rst       = rst_req;
    rst_req   = 1'b0;
    start     = start_req;
    burst_len = len_req;
    start_req = 1'b0;
    if (feed_left > 0 && $urandom_range(0, 3) == 0) begin
      w = DW'($urandom);
      fifo_q.push_back(w);
      feed_left--;
    end
    emp     = (fifo_q.size() == 0);
    rd_en   = 1'b0;
    rd_data = DW'($urandom);
    if (pend_valid) begin
      rd_en   = 1'b1;
      rd_data = pend_data;
      exp_q.push_back(pend_data);
    end else if (spur_req) begin
      rd_en = 1'b1;
      exp_q.push_back(rd_data);
    end
    spur_req = 1'b0;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    #1;
    cyc++;
    if (emp) checkOutput("rd_while_emp", 32'(rd), 32'd0);
    if (stall_prev) begin
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_data", 32'(out_data), 32'(prev_data));
    end
    pend_valid = 1'b0;
    if (rd) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      pend_valid = 1'b1;
      pend_data  = (fifo_q.size() > 0) ? fifo_q.pop_front() : '0;
    end
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (out_valid && out_ready) begin
      out_cnt++;
      got_q.push_back(out_data);
      if (exp_q.size() == 0) checkOutput("extra_word", 32'(exp_q.size()), 32'd1);
      else checkOutput("out_word", 32'(out_data), 32'(exp_q.pop_front()));
    end
    if (done) done_cnt++;
    stall_prev = out_valid && !out_ready;
    prev_data  = out_data;
    if (rst) begin
      pend_valid = 1'b0;
      stall_prev = 1'b0;
      exp_q.delete();
    end
  endtask

  task automatic beginBurst(input int len);
    start_req = 1'b1;
    len_req   = (AW+1)'(len);
    rd_cnt    = 0;
    out_cnt   = 0;
    done_cnt  = 0;
    first_rd  = -1;
    first_ov  = -1;
    cyc       = 0;
    got_q.delete();
  endtask

  task automatic runToDone(input int budget);
    for (int n = 0; n < budget && done_cnt == 0; n++) applyStimulus();
    checkOutput("done_seen", 32'(done_cnt), 32'd1);
    applyStimulus();
    checkOutput("done_pulse", 32'(done), 32'd0);
    checkOutput("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; burst_len = '0; emp = 1'b1;
    rd_en = 1'b0; rd_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_rd", 32'(rd), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);

    // Four preloaded words, consumer always ready.
    ready_mode = 0;
    fifo_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    beginBurst(4);
    runToDone(60);
    checkOutput("A_rd_cnt", 32'(rd_cnt), 32'd4);
    checkOutput("A_out_cnt", 32'(out_cnt), 32'd4);
    checkOutput("A_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("A_latency", 32'(first_ov - first_rd), 32'd2);
    if (got_q.size() == 4) begin
      checkOutput("A_w0", 32'(got_q[0]), 32'hA1);
      checkOutput("A_w3", 32'(got_q[3]), 32'hD4);
    end else checkOutput("A_got_size", 32'(got_q.size()), 32'd4);

    // Zero-length burst.
    beginBurst(0);
    applyStimulus();
    applyStimulus();
    checkOutput("Z_done", 32'(done), 32'd1);
    checkOutput("Z_busy", 32'(busy), 32'd1);
    applyStimulus();
    checkOutput("Z_done_off", 32'(done), 32'd0);
    checkOutput("Z_idle", 32'(busy), 32'd0);
    checkOutput("Z_rd_cnt", 32'(rd_cnt), 32'd0);

    // Consumer stalled: only two reads fit in the buffer.
    fifo_q = '{8'h11, 8'h22, 8'h33};
    ready_mode = 2;
    beginBurst(3);
    repeat (10) applyStimulus();
    checkOutput("S_rd_cnt", 32'(rd_cnt), 32'd2);
    checkOutput("S_rd_low", 32'(rd), 32'd0);
    checkOutput("S_valid", 32'(out_valid), 32'd1);
    checkOutput("S_head", 32'(out_data), 32'h11);
    ready_mode = 0;
    runToDone(40);
    checkOutput("S_rd_total", 32'(rd_cnt), 32'd3);
    checkOutput("S_out_cnt", 32'(out_cnt), 32'd3);

    // Empty FIFO at start, words arrive later.
    ready_mode = 0;
    beginBurst(2);
    repeat (6) applyStimulus();
    checkOutput("E_rd_cnt", 32'(rd_cnt), 32'd0);
    checkOutput("E_busy", 32'(busy), 32'd1);
    fifo_q.push_back(8'h44);
    fifo_q.push_back(8'h55);
    runToDone(40);
    checkOutput("E_rd_total", 32'(rd_cnt), 32'd2);
    checkOutput("E_out_cnt", 32'(out_cnt), 32'd2);

    // Reset in the middle of a burst with data buffered.
    fifo_q = '{8'h61, 8'h62, 8'h63, 8'h64};
    ready_mode = 2;
    beginBurst(4);
    for (int n = 0; n < 20 && !out_valid; n++) applyStimulus();
    checkOutput("R_buffered", 32'(out_valid), 32'd1);
    rst_req = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("R_valid", 32'(out_valid), 32'd0);
    checkOutput("R_busy", 32'(busy), 32'd0);
    checkOutput("R_rd", 32'(rd), 32'd0);
    fifo_q.delete();
    fifo_q.push_back(8'h66);
    ready_mode = 0;
    beginBurst(1);
    runToDone(30);
    checkOutput("R_out_cnt", 32'(out_cnt), 32'd1);
    if (got_q.size() > 0) checkOutput("R_word", 32'(got_q[0]), 32'h66);

    // Spurious ack sets a sticky error; a start during RUN is ignored.
    spur_req = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("X_err_set", 32'(err), 32'd1);
    repeat (3) applyStimulus();
    checkOutput("X_drained", 32'(out_valid), 32'd0);
    fifo_q = '{8'h71, 8'h72, 8'h73};
    ready_mode = 2;
    beginBurst(3);
    repeat (4) applyStimulus();
    start_req = 1'b1;
    len_req   = (AW+1)'(7);
    ready_mode = 0;
    runToDone(60);
    checkOutput("X_rd_cnt", 32'(rd_cnt), 32'd3);
    checkOutput("X_out_cnt", 32'(out_cnt), 32'd3);
    checkOutput("X_err_sticky", 32'(err), 32'd1);
    rst_req = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("X_err_clear", 32'(err), 32'd0);

    // Random bursts with trickling FIFO fill and a stalling consumer; last one is a full FIFO.
    for (int b = 0; b < 16; b++) begin
      int len;
      int pre;
      len = (b == 15) ? 32 : int'($urandom_range(0, 9));
      pre = (b == 15) ? 32 : int'($urandom_range(0, len));
      fifo_q.delete();
      for (int i = 0; i < pre; i++) fifo_q.push_back(DW'($urandom));
      feed_left  = len - pre;
      ready_mode = 1;
      beginBurst(len);
      runToDone(800);
      checkOutput("rand_rd_cnt", 32'(rd_cnt), 32'(len));
      checkOutput("rand_out_cnt", 32'(out_cnt), 32'(len));
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
